// File: rtl/instruction_parcel_packer_if.sv
// Instruction-stream and IMEM-write signal bundle for instruction_parcel_packer.
// master = loader/injector plus memory side; slave = the packer itself.
interface instruction_parcel_packer_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 i_start;
  logic [XLEN-1:0]      i_start_addr;
  logic                 i_instr_valid;
  logic                 o_instr_ready;
  logic [XLEN-1:0]      i_instr;
  logic                 i_flush;
  logic                 o_flush_done;
  logic                 o_wr_valid;
  logic                 i_wr_ready;
  logic [XLEN-1:0]      o_wr_addr;
  logic [XLEN-1:0]      o_wr_data;
  logic [3:0]           o_wr_strb;
  logic                 o_pending_half;
  logic [CNT_WIDTH-1:0] o_instr_count;

  modport master (
    output i_start, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
    input  o_instr_ready, o_flush_done, o_wr_valid, o_wr_addr, o_wr_data,
           o_wr_strb, o_pending_half, o_instr_count
  );

  modport slave (
    input  i_start, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
    output o_instr_ready, o_flush_done, o_wr_valid, o_wr_addr, o_wr_data,
           o_wr_strb, o_pending_half, o_instr_count
  );
endinterface

// File: rtl/instruction_parcel_packer.sv
// Packs a stream of 16/32-bit RV32C instructions at halfword granularity into
// word-aligned strobed IMEM writes, carrying the spill of word-straddling instructions.
module instruction_parcel_packer #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  instruction_parcel_packer_if.slave bus
);

  localparam logic [XLEN-1:1]      PTR_HALF = 1;  // pointer counts halfwords
  localparam logic [XLEN-1:1]      PTR_WORD = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

  logic [XLEN-1:1]      ptr, ptr_nxt;
  logic [15:0]          acc, acc_nxt;
  logic [1:0]           acc_strb, acc_strb_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt;

  logic                 wr_valid;
  logic [XLEN-1:0]      wr_addr, wr_data;
  logic [3:0]           wr_strb;
  logic                 flush_done;

  logic                 emit;
  logic [XLEN-1:0]      emit_addr, emit_data;
  logic [3:0]           emit_strb;

  logic                 instr_ready, accept, flush_fire, is_c;
  logic [XLEN-1:0]      word_addr;

  // Ready never looks at valid, so upstream may wait on it before asserting valid.
  assign instr_ready = !bus.i_start && (!wr_valid || bus.i_wr_ready);
  assign accept      = bus.i_instr_valid && instr_ready;
  assign flush_fire  = bus.i_flush && instr_ready && !bus.i_instr_valid;
  assign is_c        = (bus.i_instr[1:0] != 2'b11);
  assign word_addr   = {ptr[XLEN-1:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    ptr_nxt      = ptr;
    acc_nxt      = acc;
    acc_strb_nxt = acc_strb;
    count_nxt    = count;
    emit         = 1'b0;
    emit_addr    = word_addr;
    emit_data    = '0;
    emit_strb    = 4'b0000;

    if (bus.i_start) begin
      ptr_nxt      = bus.i_start_addr[XLEN-1:1];
      acc_nxt      = '0;
      acc_strb_nxt = 2'b00;
      count_nxt    = '0;
    end else if (accept) begin
      count_nxt = count + CNT_ONE;
      unique case ({is_c, ptr[1]})
        2'b10: begin
          acc_nxt      = bus.i_instr[15:0];
          acc_strb_nxt = 2'b11;
          ptr_nxt      = ptr + PTR_HALF;
        end
        2'b11: begin
          emit         = 1'b1;
          emit_data    = {bus.i_instr[15:0], acc};
          emit_strb    = {2'b11, acc_strb};
          acc_nxt      = '0;
          acc_strb_nxt = 2'b00;
          ptr_nxt      = ptr + PTR_HALF;
        end
        2'b00: begin
          emit         = 1'b1;
          emit_data    = bus.i_instr;
          emit_strb    = 4'b1111;
          ptr_nxt      = ptr + PTR_WORD;
        end
        default: begin
          // Straddling 32-bit: low half completes this word, high half is carried.
          emit         = 1'b1;
          emit_data    = {bus.i_instr[15:0], acc};
          emit_strb    = {2'b11, acc_strb};
          acc_nxt      = bus.i_instr[31:16];
          acc_strb_nxt = 2'b11;
          ptr_nxt      = ptr + PTR_WORD;
        end
      endcase
    end else if (flush_fire && acc_strb != 2'b00) begin
      emit         = 1'b1;
      emit_data    = {16'h0000, acc};
      emit_strb    = {2'b00, acc_strb};
      acc_nxt      = '0;
      acc_strb_nxt = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      acc        <= '0;
      acc_strb   <= 2'b00;
      count      <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= 4'b0000;
      flush_done <= 1'b0;
    end else begin
      ptr        <= ptr_nxt;
      acc        <= acc_nxt;
      acc_strb   <= acc_strb_nxt;
      count      <= count_nxt;
      flush_done <= flush_fire;
      // Slot only reloads when free or draining, so a pending write never changes.
      if (emit) begin
        wr_valid <= 1'b1;
        wr_addr  <= emit_addr;
        wr_data  <= emit_data;
        wr_strb  <= emit_strb;
      end else if (bus.i_wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

  assign bus.o_instr_ready  = instr_ready;
  assign bus.o_flush_done   = flush_done;
  assign bus.o_wr_valid     = wr_valid;
  assign bus.o_wr_addr      = wr_addr;
  assign bus.o_wr_data      = wr_data;
  assign bus.o_wr_strb      = wr_strb;
  assign bus.o_pending_half = (acc_strb != 2'b00);
  assign bus.o_instr_count  = count;

endmodule
